// File: rtl/instr_fetch_sequencer_if.sv
// Bundles the instruction-memory handshake, the decode issue handshake and the
// redirect request seen by the fetch/issue sequencer.
interface instr_fetch_sequencer_if #(
    parameter int IW   = 16,
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [IW-1:0]   imem_rdata;

    logic            dec_valid;
    logic            dec_ready;
    logic [IW-1:0]   dec_instr;
    logic [IW-1:0]   dec_imm;
    logic [PC_W-1:0] dec_pc;
    logic            dec_ldm;

    logic            flush;
    logic [PC_W-1:0] flush_pc;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_instr, dec_imm, dec_pc, dec_ldm,
        input  imem_ack, imem_rdata, dec_ready, flush, flush_pc
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_imm, dec_pc, dec_ldm,
        output imem_ack, imem_rdata, dec_ready, flush, flush_pc
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Fetch/issue sequencer: fetches one word at a time, pairs LDM with its immediate,
// and hands exactly one instruction per valid/ready handshake to decode.
module instr_fetch_sequencer #(
    parameter int              IW       = 16,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic                     clk,
    input logic                     rst,
    instr_fetch_sequencer_if.master bus
);

    localparam logic [1:0] FETCH     = 2'd0;
    localparam logic [1:0] FETCH_IMM = 2'd1;
    localparam logic [1:0] ISSUE     = 2'd2;

    localparam logic [4:0] OP_LDM = 5'b00001;

    function automatic logic [PC_W-1:0] pcInc(input logic [PC_W-1:0] p);
        return p + PC_W'(1);
    endfunction

    function automatic logic isLdm(input logic [IW-1:0] w);
        return w[IW-1 -: 5] == OP_LDM;
    endfunction

    logic [1:0]      state;
    logic [PC_W-1:0] pc;
    logic [IW-1:0]   instrQ;
    logic [IW-1:0]   immQ;
    logic [PC_W-1:0] pcQ;
    logic            ldmQ;

    logic fetching;
    logic reqOut;
    logic ackTaken;
    logic validOut;

    assign fetching = (state == FETCH) || (state == FETCH_IMM);

    // Request is masked by reset and flush so that an abandoned fetch can never be acked.
    assign reqOut   = rst & fetching & ~bus.flush;
    assign ackTaken = reqOut & bus.imem_ack;
    assign validOut = (state == ISSUE) & ~bus.flush;

    assign bus.imem_req  = reqOut;
    assign bus.imem_addr = pc;
    assign bus.dec_valid = validOut;
    assign bus.dec_instr = instrQ;
    assign bus.dec_imm   = immQ;
    assign bus.dec_pc    = pcQ;
    assign bus.dec_ldm   = ldmQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            instrQ <= '0;
            immQ   <= '0;
            pcQ    <= '0;
            ldmQ   <= 1'b0;
        end else if (bus.flush) begin
            state <= FETCH;
            pc    <= bus.flush_pc;
        end else begin
            case (state)
                FETCH: begin
                    if (ackTaken) begin
                        instrQ <= bus.imem_rdata;
                        pcQ    <= pc;
                        pc     <= pcInc(pc);
                        ldmQ   <= isLdm(bus.imem_rdata);
                        if (isLdm(bus.imem_rdata)) begin
                            state <= FETCH_IMM;
                        end else begin
                            immQ  <= '0;
                            state <= ISSUE;
                        end
                    end
                end
                FETCH_IMM: begin
                    if (ackTaken) begin
                        immQ  <= bus.imem_rdata;
                        pc    <= pcInc(pc);
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // No fetch-ahead: the next request starts only after decode accepts.
                    if (validOut && bus.dec_ready) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
